vc_switch_arbiter: RTL and testbench
====================================

# vc_switch_arbiter

Round-robin, packet-locking arbiter that shares one router output port (switch crossbar input) among `num_req` virtual-channel requesters. It issues a registered one-hot grant plus its binary index. The grant is held until the granted requester transfers its tail flit; the priority pointer then advances past the winner. It sits between the per-VC input buffers and the crossbar multiplexer select of each output port in the VC router.

## Interface
- `num_req`, default 8: number of requesters; any value ≥ 2.
- `num_req_log`, default 3: width of the binary grant index; must equal ceil(log2(`num_req`)).
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input `num_req`: per-requester request; bit k high while VC k holds a flit for this port.
- `tail` input `num_req`: per-requester flag; bit k high when VC k's current head-of-buffer flit is a tail (or single-flit packet).
- `ready` input 1: downstream (crossbar/output credit) can accept a flit this cycle.
- `grant_oh` output `num_req`: registered one-hot grant; all-zero when idle.
- `grant_id` output `num_req_log`: binary index of `grant_oh`; 0 when idle.
- `grant_valid` output 1: a grant is held.
- `xfer` output 1: combinational flit-transfer strobe this cycle.

## Operation
- State machine: IDLE, LOCKED. Reset: IDLE, `ptr`=0, `grant_oh`=0, `grant_id`=0, `grant_valid`=0.
- Round-robin pick: the first set bit of the pick vector, scanning k = `ptr`, `ptr`+1, …, wrapping modulo `num_req`.
- IDLE: the pick vector is `req`. If it is nonzero, register the winner into `grant_oh`, set `grant_valid`, and go to LOCKED. Otherwise stay in IDLE.
- LOCKED, transfer: `xfer` = `grant_valid` & `req[g]` & `ready`, where g = `grant_id`.
- LOCKED, body transfer: `xfer` with `tail[g]`=0 keeps the grant unchanged.
- LOCKED, tail transfer: `xfer` with `tail[g]`=1 sets `ptr` to (g+1) mod `num_req`, wrapping from `num_req`-1 to 0.
  - The same cycle, re-arbitrate using `req` & ~`grant_oh` and the new `ptr`.
  - Nonzero result: load the new grant and stay LOCKED (back-to-back packets, no bubble).
  - Zero result: clear the grant and go to IDLE.
- LOCKED, `req[g]` low or `ready` low: hold the grant, no transfer. The lock is never broken by request withdrawal (no timeout).
- `ptr` changes only on a tail transfer, never on grant issue.
- `req`/`tail` bits of non-granted requesters are ignored while LOCKED.
- Reset asserted in any state, including mid-packet: next cycle is IDLE with all outputs at reset values. An in-flight packet is abandoned.

## Timing
- Request to grant: 1 cycle. `req` sampled at edge t in IDLE gives `grant_valid` from cycle t+1.
- Tail transfer in cycle t: the next grant (or idle outputs) appears in cycle t+1. `xfer` may be high in cycle t+1 for the new winner.
- `xfer` is a combinational function of registered grant state, `req`, and `ready`. No other combinational input-to-output paths exist.
- `grant_id` is a pure decode of registered `grant_oh`, so it is valid in the same cycle as `grant_oh`.
- Throughput: one flit per cycle while `ready` and `req[g]` stay high, across packet boundaries.

## Structure
- Shared package/header `router_vc_pkg`: state encoding localparams (IDLE=1'b0, LOCKED=1'b1) and the `num_req_log` derivation function, so sibling allocators use the same encoding.
- One sub-module: the codebase's `encoder` (one-hot to binary), instantiated with `lenght_in`=`num_req` and `lenght_out`=`num_req_log`, to produce `grant_id` from `grant_oh`.
- The rotate-and-pick logic is a local function or generate block, not a separate module.

## Test plan
- Reset/idle: hold `rst` 2 cycles with `req`=8'hFF, then release. Outputs are 0 during reset; `grant_oh`=8'h01, `grant_id`=0 one cycle after release.
- Fairness: `req`=8'hFF, `ready`=1, every flit a tail. Grants rotate 0,1,2,…,7,0 in consecutive cycles with `xfer` high every cycle.
- Lock: `req`=8'h24 (VC 2, VC 5), VC 2 sends a 4-flit packet with `tail` on flit 4 and `ready` toggling 1,0,1. `grant_id`=2 throughout, `xfer` pulses only when `ready`=1, then `grant_id`=5 the cycle after the tail.
- Wrap: `ptr`=7 via a tail transfer from VC 6, then `req`=8'h81. VC 7 is granted, then VC 0 after VC 7's tail; `ptr` wraps to 0.
- Stall and drop: a granted VC 3 deasserts `req[3]` mid-packet for 5 cycles while VC 4 requests. The grant stays 3 and `xfer`=0 until `req[3]` returns.
- Mid-packet reset: assert `rst` on body flit 2 of a VC 1 packet. The next cycle shows `grant_valid`=0 and `ptr`=0, and VC 0 wins if `req`=8'h03.

Source files
------------

// File: rtl/router_vc_pkg.sv
// Shared definitions for the VC router allocators: FSM encoding and index-width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package router_vc_pkg;

  // Arbiter state encoding, shared so sibling allocators agree on it.
  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    IDLE   = ST_IDLE,
    LOCKED = ST_LOCKED
  } arb_state_t;

  // Width of a binary index able to address n requesters (at least 1 bit).
  function automatic int calc_num_req_log(input int n);
    for (int w = 1; w < 32; w++) begin
      if ((1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/encoder.sv
// One-hot to binary encoder; all-zero input encodes to 0.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module encoder #(
  parameter int lenght_in  = 8,
  parameter int lenght_out = 3
) (
  input  logic [lenght_in-1:0]  i_onehot,
  output logic [lenght_out-1:0] o_bin
);

  // OR together the indices of set bits; a one-hot input yields its index.
  always_comb begin
    o_bin = '0;
    for (int k = 0; k < lenght_in; k++) begin
      if (i_onehot[k]) o_bin = o_bin | lenght_out'(k);
    end
  end

endmodule

// File: rtl/vc_switch_arbiter.sv
// Round-robin, packet-locking arbiter sharing one output port among num_req VCs.
// Latency: request to registered grant 1 cycle; back-to-back packets without a bubble.
// Backpressure: ready low or req[g] low holds the grant with no transfer; lock ends only on a tail transfer.
module vc_switch_arbiter
  import router_vc_pkg::*;
#(
  parameter int num_req     = 8,
  parameter int num_req_log = calc_num_req_log(num_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [num_req-1:0]     req,
  input  logic [num_req-1:0]     tail,
  input  logic                   ready,
  output logic [num_req-1:0]     grant_oh,
  output logic [num_req_log-1:0] grant_id,
  output logic                   grant_valid,
  output logic                   xfer
);

  arb_state_t             r_state;
  logic [num_req_log-1:0] r_ptr;
  logic [num_req-1:0]     r_grant_oh;
  logic                   r_grant_valid;

  logic [num_req_log-1:0] w_grant_id;
  logic                   w_xfer;
  logic                   w_tail_xfer;
  logic [num_req_log-1:0] w_next_ptr;
  logic [num_req-1:0]     w_pick_vec;
  logic [num_req_log-1:0] w_pick_ptr;
  logic [num_req-1:0]     w_pick_oh;

  // First set bit of vec scanning from ptr upward, wrapping modulo num_req.
  function automatic logic [num_req-1:0] rr_pick(
    input logic [num_req-1:0]     vec,
    input logic [num_req_log-1:0] ptr
  );
    logic [num_req-1:0]     res;
    logic                   found;
    logic [num_req_log-1:0] idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      idx = num_req_log'((int'(ptr) + i) % num_req);
      if (!found && vec[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  encoder #(
    .lenght_in  (num_req),
    .lenght_out (num_req_log)
  ) u_grant_enc (
    .i_onehot (r_grant_oh),
    .o_bin    (w_grant_id)
  );

  // Transfer strobe and next pointer; the pick vector excludes the finishing winner on a tail.
  always_comb begin
    w_xfer      = r_grant_valid & req[w_grant_id] & ready;
    w_tail_xfer = w_xfer & tail[w_grant_id];
    w_next_ptr  = (w_grant_id == num_req_log'(num_req - 1)) ? '0 : w_grant_id + 1'b1;
    if (r_state == IDLE) begin
      w_pick_vec = req;
      w_pick_ptr = r_ptr;
    end else begin
      w_pick_vec = req & ~r_grant_oh;
      w_pick_ptr = w_next_ptr;
    end
    w_pick_oh = rr_pick(w_pick_vec, w_pick_ptr);
  end

  // Arbiter FSM: grant from IDLE, hold while LOCKED, re-arbitrate on tail transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant_oh    <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pick_vec) begin
            r_grant_oh    <= w_pick_oh;
            r_grant_valid <= 1'b1;
            r_state       <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_tail_xfer) begin
            r_ptr <= w_next_ptr;
            if (|w_pick_vec) begin
              r_grant_oh <= w_pick_oh;
            end else begin
              r_grant_oh    <= '0;
              r_grant_valid <= 1'b0;
              r_state       <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign grant_oh    = r_grant_oh;
  assign grant_id    = w_grant_id;
  assign grant_valid = r_grant_valid;
  assign xfer        = w_xfer;

endmodule

// File: tb/tb_vc_switch_arbiter.sv
// Randomized and directed scoreboard bench for vc_switch_arbiter.
// Latency: expected outputs queued per cycle and checked by an independent monitor.
// Backpressure: ready is driven randomly and in directed toggle patterns.
module tb_vc_switch_arbiter;

  localparam int N  = 8;
  localparam int NL = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  tail;
  logic          ready;
  logic [N-1:0]  grant_oh;
  logic [NL-1:0] grant_id;
  logic          grant_valid;
  logic          xfer;

  typedef struct {
    logic [N-1:0]  oh;
    logic [NL-1:0] id;
    logic          vld;
    logic          xf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: current owner (-1 when idle) and round-robin start point.
  int m_owner = -1;
  int m_ptr   = 0;

  vc_switch_arbiter #(.num_req(N), .num_req_log(NL)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .tail        (tail),
    .ready       (ready),
    .grant_oh    (grant_oh),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .xfer        (xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) begin
      if (v[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs for it, advance the model.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl, input logic rd);
    exp_t e;
    logic [N-1:0] others;
    @(posedge clk);
    #1;
    rst   = r;
    req   = rq;
    tail  = tl;
    ready = rd;
    e.vld = (m_owner >= 0);
    e.oh  = e.vld ? (N'(1) << m_owner) : '0;
    e.id  = e.vld ? NL'(m_owner) : '0;
    e.xf  = e.vld && rq[m_owner] && rd;
    exp_q.push_back(e);
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      m_owner = first_from(rq, m_ptr);
    end else if (e.xf && tl[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      others  = rq & ~(N'(1) << m_owner);
      m_owner = first_from(others, m_ptr);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_valid", 32'(grant_valid), 32'(e.vld));
        chk("grant_oh",    32'(grant_oh),    32'(e.oh));
        chk("grant_id",    32'(grant_id),    32'(e.id));
        chk("xfer",        32'(xfer),        32'(e.xf));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    req   = 8'hFF;
    tail  = 8'h00;
    ready = 1'b0;

    // Reset held two cycles with all requests up, then first grant goes to VC 0.
    step(1'b1, 8'hFF, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 8'h00, 1'b0);
    step(1'b0, 8'hFF, 8'h00, 1'b0);

    // Fairness: every flit a tail, grants rotate each cycle.
    for (int i = 0; i < 10; i++) step(1'b0, 8'hFF, 8'hFF, 1'b1);

    // Lock: VC 2 four-flit packet with ready toggling, then VC 5.
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h24, 8'h00, 1'b1);
    step(1'b0, 8'h24, 8'h00, 1'b1);
    step(1'b0, 8'h24, 8'h00, 1'b0);
    step(1'b0, 8'h24, 8'h00, 1'b1);
    step(1'b0, 8'h24, 8'h00, 1'b0);
    step(1'b0, 8'h24, 8'h00, 1'b1);
    step(1'b0, 8'h24, 8'h04, 1'b1);
    step(1'b0, 8'h20, 8'h20, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Wrap: VC 6 tail moves the pointer to 7, then 7 beats 0, then 0 follows.
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h40, 8'h40, 1'b1);
    step(1'b0, 8'h40, 8'h40, 1'b1);
    step(1'b0, 8'h81, 8'h81, 1'b1);
    step(1'b0, 8'h81, 8'h81, 1'b1);
    step(1'b0, 8'h01, 8'h01, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Stall: VC 3 drops its request mid-packet while VC 4 waits.
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h08, 8'h00, 1'b1);
    step(1'b0, 8'h08, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h10, 8'h10, 1'b1);
    step(1'b0, 8'h18, 8'h00, 1'b1);
    step(1'b0, 8'h18, 8'h08, 1'b1);
    step(1'b0, 8'h10, 8'h10, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Mid-packet reset on VC 1 body flit 2, then VC 0 wins with req=03.
    step(1'b1, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h02, 8'h00, 1'b1);
    step(1'b0, 8'h02, 8'h00, 1'b1);
    step(1'b1, 8'h02, 8'h00, 1'b1);
    step(1'b0, 8'h03, 8'h00, 1'b1);
    step(1'b0, 8'h03, 8'h01, 1'b1);
    step(1'b0, 8'h02, 8'h02, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           N'($urandom),
           N'($urandom) & N'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
